mem_copy_master: RTL and testbench

- Bus-master DMA copy engine on the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Acts as the initiator toward the same word-addressed memory responder the core uses.
- Accepts one copy command: source address, destination address, word count. Moves the data as alternating single-word reads and writes.
- Reports completion, error status and progress.

---
 rtl/mem_copy_master.sv | 135 +++++++++++++
 tb/tb_mem_copy_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// Single-channel DMA copy engine on the picorv32 native memory bus.
// Copies one word at a time: a read, then a write, from ascending addresses.
module mem_copy_master #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       src_ptr, dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept, launch, hs, timeout, last;

  assign cmd_ready = (state == IDLE);
  assign mem_instr = 1'b0;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    launch    = accept && (cmd_len != '0) && (cmd_src[1:0] == 2'b00) && (cmd_dst[1:0] == 2'b00);
    hs        = mem_valid && mem_ready;
    timeout   = mem_valid && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    last      = (remaining == LEN_W'(1));
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = READ;
      READ:    if (hs) state_nxt = WRITE;
               else if (timeout) state_nxt = IDLE;
      WRITE:   if (hs) state_nxt = last ? IDLE : READ;
               else if (timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      case (state)
        IDLE: if (accept) begin
          words_done <= '0;
          err        <= 1'b0;
          if (launch) begin
            busy      <= 1'b1;
            mem_valid <= 1'b1;
            mem_addr  <= cmd_src;
            mem_wstrb <= 4'h0;
            wait_cnt  <= '0;
          end else begin
            // Zero length completes cleanly; otherwise the command was misaligned.
            done <= 1'b1;
            err  <= (cmd_len != '0);
          end
        end
        READ: if (hs) begin
          mem_addr  <= dst_ptr;
          mem_wdata <= mem_rdata;
          mem_wstrb <= 4'hF;
          wait_cnt  <= '0;
        end else if (timeout) begin
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          err       <= 1'b1;
        end
        WRITE: if (hs) begin
          words_done <= words_done + LEN_W'(1);
          if (last) begin
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            mem_addr  <= src_ptr + 32'd4;
            mem_wstrb <= 4'h0;
            wait_cnt  <= '0;
          end
        end else if (timeout) begin
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          err       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address/count bookkeeping carries no reset: it is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_ptr   <= cmd_src;
      dst_ptr   <= cmd_dst;
      remaining <= cmd_len;
    end else if (state == WRITE && hs) begin
      src_ptr   <= src_ptr + 32'd4;
      dst_ptr   <= dst_ptr + 32'd4;
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: random-latency memory responder plus a
// word-by-word copy model that predicts the bus transaction log and memory image.
module tb_mem_copy_master;
  localparam int LEN_W = 16;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_src = '0;
  logic [31:0]      cmd_dst = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             busy, done, err;
  logic [LEN_W-1:0] words_done;
  logic             mem_valid, mem_instr;
  logic             mem_ready = 1'b0;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_rdata = '0;

  mem_copy_master #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .busy(busy),
    .done(done), .err(err), .words_done(words_done), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          max_wait;
    int          stall;      // never answer the Nth write (0 = never stall)
    logic        exp_err;
    int          exp_words;
    int          exp_cycles; // accept-to-done cycles, -1 = don't care
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  txn_t log_q[$];
  txn_t exp_q[$];

  // responder state
  int   max_wait = 0, stall_write = 0, writes_begun = 0, wait_left = 0;
  int   stab_err = 0, valid_seen = 0, cur_cycles = 0, abort_cycles = 0, done_cnt = 0;
  bit   pending = 0, in_txn = 0, rst_seen = 1;
  txn_t pend_t;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;

  function automatic int idx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_seen <= !resetn;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pending) begin
      pending   = 0;
      mem_ready = 1'b0;
      if (!rst_seen) begin
        log_q.push_back(pend_t);
        if (pend_t.wr) mem[idx(pend_t.addr)] = pend_t.data;
      end
    end
    if (mem_valid) begin
      valid_seen++;
      if (!in_txn) begin
        in_txn     = 1;
        h_addr     = mem_addr;
        h_wdata    = mem_wdata;
        h_wstrb    = mem_wstrb;
        cur_cycles = 0;
        wait_left  = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        if (mem_wstrb != 4'h0) writes_begun++;
        if (mem_wstrb != 4'h0 && mem_wstrb != 4'hF) stab_err++;
      end else if (mem_addr != h_addr || mem_wstrb != h_wstrb ||
                   (h_wstrb != 4'h0 && mem_wdata != h_wdata)) begin
        stab_err++;
      end
      cur_cycles++;
      if (!(h_wstrb != 4'h0 && writes_begun == stall_write)) begin
        if (wait_left == 0) begin
          mem_ready   = 1'b1;
          pending     = 1;
          in_txn      = 0;
          pend_t.wr   = (h_wstrb != 4'h0);
          pend_t.addr = h_addr;
          pend_t.data = pend_t.wr ? h_wdata : mem[idx(h_addr)];
          mem_rdata   = pend_t.wr ? $urandom : pend_t.data;
        end else begin
          wait_left--;
        end
      end
    end else if (in_txn) begin
      in_txn       = 0;
      abort_cycles = cur_cycles;
    end
  end

  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit tail_read);
    txn_t t;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      b = d + 32'(4 * i);
      t.wr = 1'b0; t.addr = a; t.data = ref_mem[idx(a)];
      exp_q.push_back(t);
      ref_mem[idx(b)] = t.data;
      t.wr = 1'b1; t.addr = b;
      exp_q.push_back(t);
    end
    if (tail_read) begin
      a = s + 32'(4 * n);
      t.wr = 1'b0; t.addr = a; t.data = ref_mem[idx(a)];
      exp_q.push_back(t);
    end
  endtask

  task automatic prepare();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    ref_mem = mem;
    exp_q.delete();
    log_q.delete();
  endtask

  task automatic compare_results(input string tag);
    int nm = 0;
    check({tag, "_txn_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data) nm++;
    check({tag, "_txn_content"}, nm, 0);
    nm = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nm++;
    check({tag, "_mem_image"}, nm, 0);
    check({tag, "_bus_stable"}, stab_err, 0);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_row(input vec_t v, input string tag);
    bit degenerate;
    int n_ok, cycles, vs0, dc0;
    prepare();
    degenerate = (v.len == 0) || (v.src[1:0] != 2'b00) || (v.dst[1:0] != 2'b00);
    n_ok = degenerate ? 0 : ((v.stall > 0) ? v.stall - 1 : v.len);
    model_copy(v.src, v.dst, n_ok, !degenerate && v.stall > 0);
    max_wait = v.max_wait; stall_write = v.stall; writes_begun = 0;
    vs0 = valid_seen; dc0 = done_cnt;
    check({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    cmd_src = v.src; cmd_dst = v.dst; cmd_len = LEN_W'(v.len); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(cycles);
    check({tag, "_done_seen"}, done, 1);
    if (v.exp_cycles >= 0) check({tag, "_latency"}, cycles, v.exp_cycles);
    check({tag, "_err"}, err, v.exp_err);
    check({tag, "_words_done"}, words_done, v.exp_words);
    check({tag, "_busy_clear"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_err_held"}, err, v.exp_err);
    @(negedge clk);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
    compare_results(tag);
    if (degenerate) check({tag, "_no_bus"}, valid_seen - vs0, 0);
    if (v.stall > 0) check({tag, "_timeout_cycles"}, abort_cycles, TMO);
    stall_write = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   cycles, dc0, rdy_bad;

    tbl[0] = '{32'h100, 32'h200, 3, 0, 0, 1'b0, 3, 6};
    tbl[1] = '{32'h100, 32'h200, 3, 5, 0, 1'b0, 3, -1};
    tbl[2] = '{32'h100, 32'h200, 0, 0, 0, 1'b0, 0, 0};
    tbl[3] = '{32'h102, 32'h200, 2, 0, 0, 1'b1, 0, 0};
    tbl[4] = '{32'h100, 32'h203, 2, 0, 0, 1'b1, 0, 0};
    tbl[5] = '{32'h100, 32'h104, 4, 3, 0, 1'b0, 4, -1};
    tbl[6] = '{32'h100, 32'h200, 3, 0, 2, 1'b1, 1, 19};
    tbl[7] = '{32'hFFFF_FFF8, 32'h300, 3, 2, 0, 1'b0, 3, -1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_instr", mem_instr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words_done", words_done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    resetn = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) run_row(tbl[r], $sformatf("row%0d", r));

    for (int k = 0; k < 6; k++) begin
      v.src      = 32'h400 + 32'(4 * $urandom_range(0, 40));
      v.dst      = (k % 2 == 1) ? v.src + 32'(4 * $urandom_range(1, 3))
                                : 32'h600 + 32'(4 * $urandom_range(0, 40));
      v.len      = int'($urandom_range(1, 8));
      v.max_wait = int'($urandom_range(0, 5));
      v.stall    = 0;
      v.exp_err  = 1'b0;
      v.exp_words = v.len;
      v.exp_cycles = -1;
      run_row(v, $sformatf("rand%0d", k));
    end

    // reset during the second read of a 4-word copy
    prepare();
    max_wait = 0; writes_begun = 0;
    model_copy(32'h100, 32'h200, 1, 1'b0);
    dc0 = done_cnt;
    cmd_src = 32'h100; cmd_dst = 32'h200; cmd_len = LEN_W'(4); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_words_before", words_done, 1);
    check("rstmid_second_read_addr", mem_addr, 32'h104);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rstmid_mem_valid", mem_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_words_done", words_done, 0);
    check("rstmid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check("rstmid_no_done", done_cnt - dc0, 0);
    compare_results("rstmid");
    run_row(tbl[0], "after_rst");

    // second command held on cmd_valid during a copy
    prepare();
    max_wait = 2; writes_begun = 0;
    model_copy(32'h100, 32'h200, 2, 1'b0);
    model_copy(32'h300, 32'h380, 3, 1'b0);
    dc0 = done_cnt;
    cmd_src = 32'h100; cmd_dst = 32'h200; cmd_len = LEN_W'(2); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_src = 32'h300; cmd_dst = 32'h380; cmd_len = LEN_W'(3);
    cycles = 0; rdy_bad = 0;
    while (!done && cycles < 3000) begin
      if (cmd_ready) rdy_bad++;
      @(negedge clk);
      cycles++;
    end
    check("b2b_ready_low_while_busy", rdy_bad, 0);
    check("b2b_first_done", done, 1);
    check("b2b_ready_with_done", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_second_started", busy, 1);
    wait_done(cycles);
    check("b2b_second_done", done, 1);
    check("b2b_second_words", words_done, 3);
    repeat (2) @(negedge clk);
    check("b2b_done_count", done_cnt - dc0, 2);
    compare_results("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
